// File: rtl/btb_update_ctrl_pkg.sv
// Shared BTB widths, write-bus layout, correction entry and update-FSM encodings.
package btb_update_ctrl_pkg;

  localparam int BtbWbusWidth = 63;
  localparam int BtbAddrWidth = 7;
  localparam int BiatWidth    = 22;
  localparam int PcWidth      = 32;

  typedef enum logic [1:0] {
    BTBU_INIT  = 2'd0,
    BTBU_RUN   = 2'd1,
    BTBU_FLUSH = 2'd2
  } btbu_state_e;

  typedef struct packed {
    logic                    we;
    logic                    wvalid;
    logic [BtbAddrWidth-1:0] waddr;
    logic [BiatWidth-1:0]    wtag;
    logic [PcWidth-1:0]      wpc;
  } btb_wbus_t;

  typedef struct packed {
    logic               op;
    logic [PcWidth-1:0] pc;
    logic [PcWidth-1:0] tgt;
  } upd_entry_t;

endpackage

// File: rtl/btb_upd_fifo.sv
// Correction FIFO: up to two pushes (wr0 older) and one pop per cycle; clr empties it.
// Read data is combinational from the head; the writer must respect count to avoid overflow.
module btb_upd_fifo
  import btb_update_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr0_v,
  input  upd_entry_t               wr0_dat,
  input  logic                     wr1_v,
  input  upd_entry_t               wr1_dat,
  input  logic                     rd_en,
  output upd_entry_t               rd_dat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  upd_entry_t      mem [DEPTH];
  logic [PW-1:0]   wp;
  logic [PW-1:0]   rp;
  logic [PW-1:0]   wp_inc;

  assign wp_inc = wp + PW'(1);
  assign rd_dat = mem[rp];

  // Storage has no reset; only pointers and count carry state.
  always_ff @(posedge clk) begin
    if (wr0_v) mem[wp] <= wr0_dat;
    if (wr1_v) mem[wr0_v ? wp_inc : wp] <= wr1_dat;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp + PW'(wr0_v) + PW'(wr1_v);
      rp    <= rp + PW'(rd_en);
      count <= count + CW'(wr0_v) + CW'(wr1_v) - CW'(rd_en);
    end
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// BTB write sequencer: index walk on reset/flush, then drains pipe corrections one per cycle.
// Latency 2 cycles accept->write when empty; rdy drops with FIFO fill and during flush/walk.
module btb_update_ctrl
  import btb_update_ctrl_pkg::*;
#(
  parameter int IDX_W = BtbAddrWidth,
  parameter int TAG_W = BiatWidth,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    req0_v_i,
  input  logic                    req0_op_i,
  input  logic [PcWidth-1:0]      req0_pc_i,
  input  logic [PcWidth-1:0]      req0_tgt_i,
  output logic                    req0_rdy_o,
  input  logic                    req1_v_i,
  input  logic                    req1_op_i,
  input  logic [PcWidth-1:0]      req1_pc_i,
  input  logic [PcWidth-1:0]      req1_tgt_i,
  output logic                    req1_rdy_o,
  output logic [BtbWbusWidth-1:0] w_obus,
  output logic                    busy_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  btbu_state_e   state;
  logic [IDX_W:0] idx;
  logic [CW-1:0] count;
  btb_wbus_t     wbus_q;
  upd_entry_t    ent0;
  upd_entry_t    ent1;
  upd_entry_t    head;
  logic          run;
  logic          acc0;
  logic          acc1;
  logic          coalesce;
  logic          push0;
  logic          deq;
  logic          unused_head_lsb;

  assign run        = (state == BTBU_RUN);
  assign req0_rdy_o = run && !flush_i && (count <= CW'(DEPTH - 1));
  assign req1_rdy_o = run && !flush_i && (count <= CW'(DEPTH - 2));
  assign acc0       = req0_v_i && req0_rdy_o;
  assign acc1       = req1_v_i && req1_rdy_o;

  // Same-index pair: the younger pipe1 update supersedes pipe0.
  assign coalesce = acc0 && acc1 && (req0_pc_i[3 +: IDX_W] == req1_pc_i[3 +: IDX_W]);
  assign push0    = acc0 && !coalesce;
  assign deq      = run && !flush_i && (count != '0);

  assign ent0 = '{op: req0_op_i, pc: req0_pc_i, tgt: req0_tgt_i};
  assign ent1 = '{op: req1_op_i, pc: req1_pc_i, tgt: req1_tgt_i};

  btb_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush_i),
    .wr0_v   (push0),
    .wr0_dat (ent0),
    .wr1_v   (acc1),
    .wr1_dat (ent1),
    .rd_en   (deq),
    .rd_dat  (head),
    .count   (count)
  );

  assign unused_head_lsb = ^head.pc[2:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= BTBU_INIT;
      idx    <= '0;
      wbus_q <= '0;
    end else begin
      case (state)
        BTBU_INIT, BTBU_FLUSH: begin
          if (flush_i) begin
            idx       <= '0;
            wbus_q.we <= 1'b0;
          end else if (idx[IDX_W]) begin
            state     <= BTBU_RUN;
            wbus_q.we <= 1'b0;
          end else begin
            wbus_q <= '{we: 1'b1, wvalid: 1'b0, waddr: idx[IDX_W-1:0], wtag: '0, wpc: '0};
            idx    <= idx + (IDX_W + 1)'(1);
          end
        end
        BTBU_RUN: begin
          if (flush_i) begin
            state     <= BTBU_FLUSH;
            idx       <= '0;
            wbus_q.we <= 1'b0;
          end else if (deq) begin
            wbus_q <= '{we:     1'b1,
                        wvalid: head.op,
                        waddr:  head.pc[3 +: IDX_W],
                        wtag:   head.pc[IDX_W + 3 +: TAG_W],
                        wpc:    head.op ? head.tgt : '0};
          end else begin
            wbus_q.we <= 1'b0;
          end
        end
        default: begin
          state <= BTBU_INIT;
          idx   <= '0;
        end
      endcase
    end
  end

  assign w_obus = wbus_q;
  assign busy_o = rst || (state != BTBU_RUN);

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Scoreboard bench for btb_update_ctrl: stimulus pushes expected writes, a monitor pops them.
module tb_btb_update_ctrl;
  import btb_update_ctrl_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        v0 = 1'b0, op0 = 1'b0, v1 = 1'b0, op1 = 1'b0;
  logic [31:0] pc0 = '0, tgt0 = '0, pc1 = '0, tgt1 = '0;
  logic        rdy0, rdy1, busy;
  logic [62:0] wbus;

  always #5 clk = ~clk;

  btb_update_ctrl #(.IDX_W(7), .TAG_W(22), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .req0_v_i   (v0),
    .req0_op_i  (op0),
    .req0_pc_i  (pc0),
    .req0_tgt_i (tgt0),
    .req0_rdy_o (rdy0),
    .req1_v_i   (v1),
    .req1_op_i  (op1),
    .req1_pc_i  (pc1),
    .req1_tgt_i (tgt1),
    .req1_rdy_o (rdy1),
    .w_obus     (wbus),
    .busy_o     (busy)
  );

  typedef struct {
    logic [62:0] word;
    int          exp_cyc;
  } sb_t;

  sb_t sb[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  walk_left = 0;   // non-RUN cycles remaining; RUN when 0
  int  mcount = 0;      // entries accepted but not yet drained
  bit  rebuild = 1'b0;
  bit  was_walk = 1'b1;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [62:0] walk_word(input int i);
    logic [6:0] a;
    a = 7'(i);
    return {1'b1, 1'b0, a, 22'd0, 32'd0};
  endfunction

  function automatic logic [62:0] corr_word(input logic op, input logic [31:0] pc,
                                            input logic [31:0] tgt);
    return {1'b1, op, pc[9:3], pc[31:10], op ? tgt : 32'd0};
  endfunction

  function automatic logic [31:0] rpc();
    logic [31:0] p;
    p      = $urandom;
    p[9:3] = 7'($urandom_range(0, 5));
    return p;
  endfunction

  task automatic push_walk();
    for (int i = 0; i < 128; i++) sb.push_back('{walk_word(i), -1});
  endtask

  // Monitor: every write on the bus must be the next expected one.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (!rst && wbus[62]) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got %h, expected no write (cycle %0d)", wbus, cyc);
        end else begin
          e = sb.pop_front();
          check("w_obus", {1'b0, wbus}, {1'b0, e.word});
          if (e.exp_cyc >= 0) check("latency", 64'(cyc), 64'(e.exp_cyc));
        end
      end
    end
  end

  task automatic reset_dut();
    @(posedge clk);
    #1;
    rst = 1'b1; flush = 1'b0; v0 = 1'b0; v1 = 1'b0;
    #1;
    check("busy_in_reset", {63'd0, busy}, 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset_wbus", {1'b0, wbus}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd1);
    check("reset_rdy", {62'd0, rdy0, rdy1}, 64'd0);
    sb.delete();
    push_walk();
    walk_left = 128;
    mcount    = 0;
    rebuild   = 1'b0;
    was_walk  = 1'b1;
  endtask

  task automatic step(input bit f, input bit a0, input bit o0, input logic [31:0] p0,
                      input logic [31:0] t0, input bit a1, input bit o1,
                      input logic [31:0] p1, input logic [31:0] t1);
    bit run, er0, er1, acc0, acc1, empty;
    int n;
    @(posedge clk);
    #1;
    if (rebuild) begin
      sb.delete();
      push_walk();
      rebuild = 1'b0;
    end
    flush = f; v0 = a0; op0 = o0; pc0 = p0; tgt0 = t0;
    v1 = a1; op1 = o1; pc1 = p1; tgt1 = t1;
    #1;
    run = (walk_left == 0);
    if (run && was_walk) check("walk_complete", 64'(sb.size()), 64'd0);
    was_walk = !run;
    er0 = run && !f && (mcount <= DEPTH - 1);
    er1 = run && !f && (mcount <= DEPTH - 2);
    check("rdy0", {63'd0, rdy0}, {63'd0, er0});
    check("rdy1", {63'd0, rdy1}, {63'd0, er1});
    check("busy", {63'd0, busy}, {63'd0, !run});
    if (f) begin
      mcount    = 0;
      walk_left = 129;
      rebuild   = 1'b1;
    end else if (run) begin
      acc0  = a0 && er0;
      acc1  = a1 && er1;
      empty = (mcount == 0);
      n     = 0;
      if (acc0 && !(acc1 && p0[9:3] == p1[9:3])) begin
        sb.push_back('{corr_word(o0, p0, t0), empty ? cyc + 2 : -1});
        n++;
      end
      if (acc1) begin
        sb.push_back('{corr_word(o1, p1, t1), empty ? cyc + 2 + n : -1});
        n++;
      end
      mcount = mcount + n - ((mcount > 0) ? 1 : 0);
    end else begin
      walk_left--;
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic wait_walk_left(input int target);
    int i = 0;
    while (walk_left != target && i < 300) begin
      idle();
      i++;
    end
    tests++;
    if (walk_left != target) begin
      fails++;
      $display("FAIL walk_wait: got walk_left %0d, expected %0d", walk_left, target);
    end
  endtask

  task automatic wait_run();
    wait_walk_left(0);
    idle();
  endtask

  initial begin
    #1;
    check("busy_at_start", {63'd0, busy}, 64'd1);
    reset_dut();
    wait_run();

    // Single install, FIFO empty: write lands two cycles after accept.
    step(1'b0, 1'b1, 1'b1, 32'h1C00_0408, 32'h1C00_0800, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) idle();

    // Distinct indices from both pipes: two back-to-back writes, pipe0 first.
    step(1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_4000, 1'b1, 1'b0, 32'h0000_0208, 32'h0000_5000);
    repeat (4) idle();

    // Same index: only pipe1's write survives.
    step(1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_6000, 1'b1, 1'b1, 32'h1C00_0100, 32'h1C00_0900);
    repeat (4) idle();

    // Both pipes held valid: readiness tracks occupancy.
    for (int i = 0; i < 30; i++)
      step(1'b0, 1'b1, 1'($urandom), rpc(), $urandom, 1'b1, 1'($urandom), rpc(), $urandom);
    repeat (6) idle();

    // Flush with entries queued, then flush again mid-walk at index 50.
    step(1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_1000, 1'b1, 1'b1, 32'h0000_0208, 32'h0000_2000);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0310, 32'h0000_3000, 1'b1, 1'b1, 32'h0000_0418, 32'h0000_4000);
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_walk_left(79);
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_run();

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 399) == 0), ($urandom_range(0, 2) != 0), 1'($urandom), rpc(),
           $urandom, ($urandom_range(0, 2) != 0), 1'($urandom), rpc(), $urandom);
    wait_run();

    // Reset in the middle of a flush walk.
    step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_walk_left(60);
    reset_dut();
    wait_run();

    for (int i = 0; i < 40; i++)
      step(1'b0, 1'($urandom), 1'($urandom), rpc(), $urandom, 1'($urandom), 1'($urandom), rpc(), $urandom);
    repeat (8) idle();
    check("drain_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
